instr_encoder: RTL

Assembles instruction-level requests (operation, register numbers, immediate, jump target) into 32-bit MIPS instruction words and writes them sequentially into instruction memory. It is the encode-side counterpart of the single-cycle datapath's opcode/funct decoder, and it loads programs into imem before or between CPU runs. Requests arrive over a valid/ready handshake. Each legal request produces one memory write.

---
 rtl/instr_encoder.sv | 95 +++++++++
 1 files changed

// File: rtl/instr_encoder.sv
// instr_encoder: packs op/register/immediate requests into MIPS words and streams them into imem.
module instr_encoder #(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0,
    parameter int DEPTH     = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    input  logic              in_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   word_count
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   DEPTH_W = (ADDR_W + 1)'(DEPTH);
    state_t            state_q;
    logic              imem_we_q, err_q;
    logic [ADDR_W-1:0] imem_addr_q;
    logic [31:0]       imem_wdata_q, word_d;
    logic [ADDR_W:0]   word_count_q, word_count_d;
    logic [5:0]        opc, funct;
    logic              accept, legal;
    assign in_ready     = (state_q == RUN) && (word_count_q < DEPTH_W);
    assign accept       = in_valid & in_ready;
    assign legal        = in_op <= 4'd9;
    assign word_count_d = word_count_q + 1'b1;
    always_comb begin
        opc   = 6'b000000;
        funct = 6'b100000;
        case (in_op)
            4'd1:    funct = 6'b100010;
            4'd2:    funct = 6'b100100;
            4'd3:    funct = 6'b100101;
            4'd4:    opc   = 6'b001000;
            4'd5:    opc   = 6'b001101;
            4'd6:    opc   = 6'b000100;
            4'd7:    opc   = 6'b000010;
            4'd8:    opc   = 6'b100011;
            4'd9:    opc   = 6'b101011;
            default: ;
        endcase
        word_d = (in_op <= 4'd3) ? {6'b000000, in_rs, in_rt, in_rd, 5'b00000, funct} :
                 (in_op == 4'd7) ? {opc, in_target} : {opc, in_rs, in_rt, in_imm};
    end
    // illegal ops still count as accepts, so in_last on one of them still ends the session
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= BASE;
            imem_wdata_q <= '0;
            err_q        <= 1'b0;
            word_count_q <= '0;
        end else begin
            imem_we_q <= 1'b0;
            if (accept) begin
                if (legal) begin
                    imem_we_q    <= 1'b1;
                    imem_addr_q  <= BASE + word_count_q[ADDR_W-1:0];
                    imem_wdata_q <= word_d;
                    word_count_q <= word_count_d;
                end else begin
                    err_q <= 1'b1;
                end
                if (in_last || (legal && word_count_d == DEPTH_W)) state_q <= DONE;
            end else if (start && state_q != RUN) begin
                state_q      <= RUN;
                imem_addr_q  <= BASE;
                err_q        <= 1'b0;
                word_count_q <= '0;
            end
        end
    end
    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign err        = err_q;
    assign word_count = word_count_q;
    assign done       = state_q == DONE;
    assign busy       = (state_q == RUN) | imem_we_q;
endmodule
